// File: rtl/c3lib_ckg_en_ctrl.sv
// Clock-gate enable controller: four-phase clk_req/clk_ack handshake with a
// wake-up delay before ack and an idle timeout before the clock is gated off.
module c3lib_ckg_en_ctrl #(
  parameter int CNT_W    = 8,
  parameter int WAKE_CYC = 2   // legal range 1..15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_req,
  input  logic             force_on,
  input  logic             scan_mode,
  input  logic [CNT_W-1:0] idle_limit,
  output logic             clk_en,
  output logic             tst_en,
  output logic             clk_ack,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_IDLE = 2'd3
  } state_t;

  localparam logic [3:0] WAKE_LOAD = 4'(WAKE_CYC - 1);

  state_t           state_q, state_d;
  logic [3:0]       wake_cnt_q, wake_cnt_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             clk_en_q, clk_en_d;
  logic             clk_ack_q, clk_ack_d;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      wake_cnt_q <= '0;
      idle_cnt_q <= '0;
      clk_en_q   <= 1'b0;
      clk_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      clk_en_q   <= clk_en_d;
      clk_ack_q  <= clk_ack_d;
    end
  end

  // Priority within each state: request first, then force_on, then expiry.
  // Counters only decrement when non-zero, so they saturate at 0.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    idle_cnt_d = idle_cnt_q;
    unique case (state_q)
      ST_OFF: begin
        if (clk_req) begin
          state_d    = ST_WAKE;
          wake_cnt_d = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (wake_cnt_q != '0) begin
          wake_cnt_d = wake_cnt_q - 4'd1;
        end else if (clk_req) begin
          state_d = ST_ON;
        end else begin
          state_d    = ST_IDLE;
          idle_cnt_d = idle_limit;
        end
      end
      ST_ON: begin
        if (!clk_req) begin
          state_d    = ST_IDLE;
          idle_cnt_d = idle_limit;
        end
      end
      ST_IDLE: begin
        if (clk_req) begin
          state_d = ST_ON;
        end else if (force_on) begin
          state_d = ST_IDLE;
        end else if (idle_cnt_q == '0) begin
          state_d = ST_OFF;
        end else begin
          idle_cnt_d = idle_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Enables are decoded from the next state and registered, so clk_en only
  // moves on rising edges and stays stable through the gater's latch window.
  always_comb begin
    clk_en_d  = (state_d != ST_OFF) | force_on;
    clk_ack_d = (state_d == ST_ON);
  end

  assign clk_en  = clk_en_q;
  assign clk_ack = clk_ack_q;
  assign state_o = state_q;
  assign tst_en  = scan_mode;

endmodule
